// File: rtl/matrix_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_result_streamer
// Purpose  : Captures a flat result matrix when the multiplier signals
//            completion, then streams its elements out in row-major order
//            over a valid/ready channel with row/col indices and a last flag.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_result_streamer #(
  parameter int ELEM_W    = 8,
  parameter int MAX_ELEMS = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        done_in,
  input  logic [MAX_ELEMS*ELEM_W-1:0] C_in,
  input  logic [7:0]                  rows,
  input  logic [7:0]                  cols,
  output logic [ELEM_W-1:0]           m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [7:0]                  m_row,
  output logic [7:0]                  m_col,
  output logic                        m_last,
  output logic                        busy,
  output logic                        ack,
  output logic                        err
);

  // Address width of the capture store; the element index itself is always
  // computed at 16 bits so that any legal rows*cols product is exact.
  localparam int IDX_W = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  localparam logic [16:0] c_MAX_ELEMS = 17'(MAX_ELEMS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              done_q;
  logic [7:0]        rows_q, cols_q;
  logic [7:0]        row_q, row_d;
  logic [7:0]        col_q, col_d;
  logic              err_q, err_d;
  logic              capture;
  logic              start;
  logic              cap_ok;
  logic              is_last;
  logic [15:0]       cap_prod;
  logic [15:0]       idx_full;
  logic [ELEM_W-1:0] mem_q [MAX_ELEMS];

  // Rising edge of the completion level; only acted on from IDLE.
  assign start    = done_in & ~done_q;

  // A job is legal only if it is non-empty and fits in the capture store.
  assign cap_prod = {8'd0, rows} * {8'd0, cols};
  assign cap_ok   = (rows != 8'd0) && (cols != 8'd0) &&
                    ({1'b0, cap_prod} <= c_MAX_ELEMS);

  // Row-major flat index of the element currently presented.
  assign idx_full = ({8'd0, row_q} * {8'd0, cols_q}) + {8'd0, col_q};
  assign is_last  = (row_q == rows_q - 8'd1) && (col_q == cols_q - 8'd1);

  // Bits of the 16-bit index above the store address are never nonzero for
  // a legal job; they are folded into a sink so they are not left dangling.
  generate
    if (IDX_W < 16) begin : g_idx_unused
      logic unused_idx_hi;
      assign unused_idx_hi = ^idx_full[15:IDX_W];
    end
  endgenerate

  // Outputs are decoded from state so reset forces them all to zero at once.
  assign m_valid = (state_q == STREAM);
  assign m_data  = m_valid ? mem_q[idx_full[IDX_W-1:0]] : '0;
  assign m_row   = m_valid ? row_q : 8'd0;
  assign m_col   = m_valid ? col_q : 8'd0;
  assign m_last  = m_valid & is_last;
  assign busy    = (state_q != IDLE);
  assign ack     = (state_q == FINISH);
  assign err     = err_q;

  // Control state, edge detector, job geometry and stream position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      rows_q  <= 8'd0;
      cols_q  <= 8'd0;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_in;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
      if (capture) begin
        rows_q <= rows;
        cols_q <= cols;
      end
    end
  end

  // Matrix snapshot taken on the start edge; pure data, so no reset needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < MAX_ELEMS; k++) begin
        mem_q[k] <= C_in[k*ELEM_W +: ELEM_W];
      end
    end
  end

  // Next-state logic: accept a job, walk the matrix on each transfer, finish.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (cap_ok) begin
            err_d   = 1'b0;
            row_d   = 8'd0;
            col_d   = 8'd0;
            state_d = STREAM;
          end else begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end
      end
      STREAM: begin
        if (m_ready) begin
          if (is_last) begin
            state_d = FINISH;
          end else if (col_q == cols_q - 8'd1) begin
            col_d = 8'd0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_result_streamer
// Purpose  : Scoreboard bench for matrix_result_streamer. Jobs push their
//            expected element stream and completion status into queues; a
//            monitor pops and compares whenever the DUT presents output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_result_streamer;

  localparam int ELEM_W    = 8;
  localparam int MAX_ELEMS = 1024;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        done_in;
  logic [MAX_ELEMS*ELEM_W-1:0] C_in;
  logic [7:0]                  rows, cols;
  logic [ELEM_W-1:0]           m_data;
  logic                        m_valid;
  logic                        m_ready;
  logic [7:0]                  m_row, m_col;
  logic                        m_last, busy, ack, err;

  typedef struct {
    logic [7:0] data;
    logic [7:0] row;
    logic [7:0] col;
    logic       last;
  } elem_t;

  elem_t exp_q[$];
  bit    err_exp_q[$];
  elem_t mon_e;
  int    compared   = 0;
  int    mismatched = 0;
  int    rdy_mode   = 0;   // 0: always ready, 1: toggle, 2: random

  matrix_result_streamer #(.ELEM_W(ELEM_W), .MAX_ELEMS(MAX_ELEMS)) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .C_in(C_in),
    .rows(rows), .cols(cols), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_row(m_row), .m_col(m_col), .m_last(m_last),
    .busy(busy), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready pattern, changed just after each rising edge.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every presented element must match the head of the expected
  // stream; it is retired only on an accepted transfer.
  always @(negedge clk) begin
    if (reset) begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_valid: got m_valid=1 data=%0h expected no output (t=%0t)", m_data, $time);
        end else begin
          mon_e = exp_q[0];
          chk("m_data", 32'(m_data), 32'(mon_e.data));
          chk("m_row",  32'(m_row),  32'(mon_e.row));
          chk("m_col",  32'(m_col),  32'(mon_e.col));
          chk("m_last", 32'(m_last), 32'(mon_e.last));
          if (m_ready) void'(exp_q.pop_front());
        end
      end
      if (ack) begin
        if (err_exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_ack: got ack=1 expected no job end (t=%0t)", $time);
        end else begin
          chk("err_at_ack", 32'(err), 32'(err_exp_q.pop_front()));
          chk("elems_left_at_ack", 32'(exp_q.size()), 32'd0);
        end
      end
    end
  end

  // Present a new job on the inputs and record what it must produce.
  task automatic start_job(input int r, input int c, input bit fixed);
    elem_t e;
    for (int k = 0; k < MAX_ELEMS; k++) C_in[k*ELEM_W +: ELEM_W] = 8'($urandom);
    if (fixed) C_in[31:0] = 32'h0102_0304;
    rows = 8'(r);
    cols = 8'(c);
    if (r > 0 && c > 0 && r * c <= MAX_ELEMS) begin
      for (int i = 0; i < r; i++) begin
        for (int j = 0; j < c; j++) begin
          e.data = C_in[(i*c+j)*ELEM_W +: ELEM_W];
          e.row  = 8'(i);
          e.col  = 8'(j);
          e.last = (i == r - 1) && (j == c - 1);
          exp_q.push_back(e);
        end
      end
      err_exp_q.push_back(1'b0);
    end else begin
      err_exp_q.push_back(1'b1);
    end
  endtask

  // Wait for ack, counting edges from the start edge. With disturb set the
  // inputs are scrambled after capture and done_in re-rises mid-stream.
  task automatic wait_done(input int limit, input bit disturb, output int cyc);
    bit fin = 0;
    cyc = 0;
    while (!fin) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        if (!disturb) begin
          done_in = 1'b0;
        end else begin
          for (int k = 0; k < MAX_ELEMS; k++) C_in[k*ELEM_W +: ELEM_W] = 8'($urandom);
          rows = 8'd7;
          cols = 8'd2;
        end
      end
      if (disturb && cyc == 2) done_in = 1'b0;
      if (disturb && cyc == 3) done_in = 1'b1;
      if (ack) begin
        chk("busy_at_ack", 32'(busy), 32'd1);
        fin = 1;
      end else if (cyc > limit) begin
        compared++;
        mismatched++;
        $display("FAIL ack_timeout: got no ack after %0d cycles expected ack", cyc);
        fin = 1;
      end
    end
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("busy_idle", 32'(busy), 32'd0);
      chk("ack_idle",  32'(ack),  32'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_last"},  32'(m_last),  32'd0);
    chk({tag, "_m_data"},  32'(m_data),  32'd0);
    chk({tag, "_m_row"},   32'(m_row),   32'd0);
    chk({tag, "_m_col"},   32'(m_col),   32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_ack"},     32'(ack),     32'd0);
    chk({tag, "_err"},     32'(err),     32'd0);
  endtask

  // Full job with ready pattern; latency is checked when always ready.
  task automatic run_job(input int r, input int c, input int mode, input bit fixed, input bit disturb);
    int  cyc;
    bit  ok;
    rdy_mode = mode;
    ok = (r > 0 && c > 0 && r * c <= MAX_ELEMS);
    start_job(r, c, fixed);
    done_in = 1'b1;
    wait_done(r * c * 4 + 20, disturb, cyc);
    if (mode == 0) chk("job_cycles", 32'(cyc), ok ? 32'(r * c + 1) : 32'd1);
    if (!ok) chk("err_after_bad_job", 32'(err), 32'd1);
    idle_check(disturb ? 3 : 2);
    done_in = 1'b0;
    idle_check(1);
  endtask

  initial begin
    int cyc;
    int r, c, sel;
    reset   = 1'b0;
    done_in = 1'b0;
    C_in    = '0;
    rows    = 8'd0;
    cols    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    idle_check(2);

    // 2x2 with fixed low bytes, always ready.
    run_job(2, 2, 0, 1'b1, 1'b0);
    // 2x3 with toggling ready.
    run_job(2, 3, 1, 1'b0, 1'b0);
    // Rejected geometries.
    run_job(0, 5, 0, 1'b0, 1'b0);
    run_job(40, 40, 0, 1'b0, 1'b0);
    // Valid job clears err.
    run_job(1, 1, 0, 1'b0, 1'b0);
    chk("err_cleared", 32'(err), 32'd0);
    // Inputs changed after capture plus a done_in edge mid-stream.
    run_job(3, 3, 0, 1'b0, 1'b1);

    // Reset in the middle of a 2x2 job after two transfers.
    rdy_mode = 0;
    start_job(2, 2, 1'b0);
    done_in = 1'b1;
    @(posedge clk); #1; done_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_zero("reset_mid");
    exp_q.delete();
    err_exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_check(5);

    // done_in already high at reset release starts a job.
    start_job(1, 2, 1'b0);
    reset   = 1'b0;
    done_in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    wait_done(40, 1'b0, cyc);
    chk("release_start_cycles", 32'(cyc), 32'd3);
    idle_check(2);

    // Full-capacity 32x32 job.
    run_job(32, 32, 0, 1'b0, 1'b0);
    chk("err_full", 32'(err), 32'd0);

    // Random jobs with random ready.
    for (int n = 0; n < 20; n++) begin
      sel = $urandom_range(0, 7);
      r   = $urandom_range(1, 6);
      c   = $urandom_range(1, 6);
      if (sel == 0) r = 0;
      if (sel == 1) begin r = 20; c = 60; end
      run_job(r, c, 2, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size() + err_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/matrix_result_streamer.md
MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001: Parameter ELEM_W, default 8, SHALL set the element width in bits.
REQ-002: Parameter MAX_ELEMS, default 1024, SHALL set the flat-bus capacity; the bus width is MAX_ELEMS*ELEM_W (8192 by default).
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005: done_in  input  1  SHALL be the multiplier completion flag; level signal, rising edge starts a job.
REQ-006: C_in  input  MAX_ELEMS*ELEM_W  SHALL be the flat result matrix; element k occupies bits [k*ELEM_W +: ELEM_W].
REQ-007: rows  input  8  SHALL give the result row count; cols  input  8  SHALL give the result column count.
REQ-008: m_data  output  ELEM_W  SHALL carry the current element; m_valid  output  1  SHALL qualify it; m_ready  input  1  SHALL be downstream acceptance.
REQ-009: m_row  output  8, m_col  output  8  SHALL give the current element's indices; m_last  output  1  SHALL mark the final element.
REQ-010: busy  output  1  SHALL be high outside IDLE; ack  output  1  SHALL pulse on job completion; err  output  1  SHALL flag a rejected job.

Function
REQ-011: States SHALL be IDLE, STREAM, FINISH.
REQ-012: done_in SHALL be registered internally (done_q); start = done_in & ~done_q, evaluated only in IDLE.
REQ-013: On start in IDLE, C_in, rows and cols SHALL be captured into internal registers in the same edge; later C_in/rows/cols changes SHALL not affect the job.
REQ-014: Capture validity: rows==0, cols==0, or rows*cols > MAX_ELEMS SHALL set err=1 and go to FINISH without asserting m_valid.
REQ-015: Valid capture SHALL clear err, set row=col=0, enter STREAM; m_valid SHALL be high on the next cycle (1-cycle start latency).
REQ-016: In STREAM, m_data SHALL equal captured element (row*cols_q + col), row-major, index computed at full precision (16 bits minimum).
REQ-017: m_valid SHALL stay high and m_data/m_row/m_col/m_last SHALL stay stable until a cycle with m_valid & m_ready (transfer).
REQ-018: On transfer, col SHALL increment; at col==cols_q-1, col wraps to 0 and row increments.
REQ-019: m_last SHALL be high exactly when row==rows_q-1 and col==cols_q-1.
REQ-020: Transfer with m_last SHALL drop m_valid on the next edge and enter FINISH; back-to-back transfers SHALL sustain one element per cycle when m_ready stays high.
REQ-021: FINISH SHALL last exactly one cycle with ack=1, then return to IDLE; err SHALL hold its value until the next start.
REQ-022: done_in edges while in STREAM or FINISH SHALL be ignored; a done_in still high on return to IDLE SHALL not restart (needs a new rising edge).
REQ-023: m_ready while m_valid is low SHALL have no effect.

Reset
REQ-024: reset low SHALL asynchronously force IDLE, m_valid=0, m_last=0, m_data=0, m_row=0, m_col=0, busy=0, ack=0, err=0, done_q=0.
REQ-025: reset asserted mid-STREAM SHALL abort the job; no remaining elements SHALL be emitted after release.
REQ-026: After reset release with done_in already high, a job SHALL start only if done_q sees the edge (done_q=0, done_in=1 on the first edge): start is taken.

Verification
REQ-027: 2x2, C_in low bytes = 0x04,0x03,0x02,0x01, m_ready=1 -> m_data 0x04,0x03,0x02,0x01 on 4 consecutive cycles, (row,col) (0,0),(0,1),(1,0),(1,1), m_last on 4th only, ack one cycle later.
REQ-028: 2x3, m_ready toggling 1,0,1,0... -> 6 transfers, data/indices stable during every stall, order row-major, m_last on element 5.
REQ-029: rows=0, cols=5 then rows=40, cols=40 (1600>1024) -> err=1, no m_valid, ack pulse, busy for 1 cycle each.
REQ-030: Change C_in and rows after start, and pulse done_in mid-stream -> output uses captured values only; no second job.
REQ-031: Assert reset after 2 of 4 transfers of a 2x2 job -> all outputs zero immediately; after release, no m_valid until a new done_in rising edge.
REQ-032: 32x32 (1024 elements, full capacity), m_ready=1 -> element 1023 read from top byte of C_in, m_last with (31,31), no err.
